// File: rtl/booth_mul_arbiter_if.sv
// Client and multiplier-side signals of the shared Booth multiplier arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface booth_mul_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       rsp0_valid;
    logic [7:0] rsp0_p;
    logic       rsp1_valid;
    logic [7:0] rsp1_p;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_p;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
        output mul_start, mul_a, mul_b,
        input  mul_p
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
        input  mul_start, mul_a, mul_b,
        output mul_p
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Booth multiplier between
// two requesters: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module booth_mul_arbiter #(
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_mul_arbiter_if.slave  bus,
    output logic                busy_o,
    output logic [7:0]          ops_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    state_t           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_start_q;
    logic [3:0]       mul_a_q;
    logic [3:0]       mul_b_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [7:0]       rsp0_p_q;
    logic [7:0]       rsp1_p_q;
    logic             busy_q;
    logic [7:0]       ops_q;

    logic             gnt0_d;
    logic             gnt1_d;

    // Ready is only offered in IDLE; on contention the side not served last wins.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (state_q == IDLE) begin
            unique case (1'b1)
                (bus.req0_valid && (!bus.req1_valid || last_grant_q)):
                    gnt0_d = 1'b1;
                (bus.req1_valid && (!bus.req0_valid || !last_grant_q)):
                    gnt1_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_p_q     <= '0;
            rsp1_p_q     <= '0;
            busy_q       <= 1'b0;
            ops_q        <= '0;
        end else begin
            mul_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt0_d || gnt1_d) begin
                        mul_a_q      <= gnt1_d ? bus.req1_a : bus.req0_a;
                        mul_b_q      <= gnt1_d ? bus.req1_b : bus.req0_b;
                        owner_q      <= gnt1_d;
                        last_grant_q <= gnt1_d;
                        mul_start_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (owner_q) begin
                            rsp1_p_q     <= bus.mul_p;
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            rsp0_p_q     <= bus.mul_p;
                            rsp0_valid_q <= 1'b1;
                        end
                        ops_q   <= ops_q + 8'd1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = gnt0_d;
    assign bus.req1_ready = gnt1_d;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_p     = rsp0_p_q;
    assign bus.rsp1_p     = rsp1_p_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign busy_o         = busy_q;
    assign ops_done_o     = ops_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: random and directed requests checked against
// a cycle-schedule model with a stub multiplier supplying products.
module tb_booth_mul_arbiter;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] ops_done;

    booth_mul_arbiter_if bus();

    booth_mul_arbiter #(.MUL_LAT(5), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .ops_done_o(ops_done)
    );

    always #5 clk = ~clk;

    function automatic int smul(logic [3:0] a, logic [3:0] b);
        int sa;
        int sb;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        return sa * sb;
    endfunction

    // Stub multiplier: garbage right after start, true product from c+4 on.
    int         mcnt;
    logic [7:0] mprod;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt      <= 0;
            bus.mul_p <= 8'h00;
        end else if (bus.mul_start) begin
            mcnt      <= 1;
            bus.mul_p <= 8'h5A;
            mprod     <= 8'(smul(bus.mul_a, bus.mul_b));
        end else if (mcnt != 0 && mcnt < 8) begin
            mcnt <= mcnt + 1;
            if (mcnt == 3) bus.mul_p <= mprod;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a handshake at cycle hs owns the unit until hs+8.
    int         k = 0;
    int         hs = -100;
    int         idle_from = 0;
    int         own = 0;
    int         nops = 0;
    bit         lg = 1'b1;
    logic [3:0] opa = '0;
    logic [3:0] opb = '0;
    logic [7:0] prod = '0;
    logic [7:0] exp_p0 = '0;
    logic [7:0] exp_p1 = '0;
    logic [7:0] exp_ops = '0;

    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic [3:0] a0 = '0;
    logic [3:0] b0 = '0;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    op_t        q0[$];
    op_t        q1[$];
    bit         rnd = 1'b0;

    task automatic drive();
        op_t op;
        if (!v0 && q0.size() > 0) begin
            op = q0.pop_front();
            v0 = 1'b1; a0 = op.a; b0 = op.b;
        end else if (!v0 && rnd && $urandom_range(0, 2) == 0) begin
            v0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
        end else if (v0 && rnd && $urandom_range(0, 15) == 0) begin
            v0 = 1'b0;
        end
        if (!v1 && q1.size() > 0) begin
            op = q1.pop_front();
            v1 = 1'b1; a1 = op.a; b1 = op.b;
        end else if (!v1 && rnd && $urandom_range(0, 2) == 0) begin
            v1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
        end else if (v1 && rnd && $urandom_range(0, 15) == 0) begin
            v1 = 1'b0;
        end
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    task automatic step();
        bit idle;
        bit r0;
        bit r1;
        @(negedge clk);
        idle = (k >= idle_from);
        r0 = idle && v0 && (!v1 || lg);
        r1 = idle && v1 && (!v0 || !lg);
        if (k == hs + 7) begin
            if (own == 0) exp_p0 = prod;
            else exp_p1 = prod;
            exp_ops++;
            nops++;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(r0));
        check("req1_ready", 32'(bus.req1_ready), 32'(r1));
        check("mul_start", 32'(bus.mul_start), 32'(k == hs + 1));
        check("busy", 32'(busy), 32'(!idle));
        check("rsp0_valid", 32'(bus.rsp0_valid), 32'(k == hs + 7 && own == 0));
        check("rsp1_valid", 32'(bus.rsp1_valid), 32'(k == hs + 7 && own == 1));
        check("rsp0_p", 32'(bus.rsp0_p), 32'(exp_p0));
        check("rsp1_p", 32'(bus.rsp1_p), 32'(exp_p1));
        if (!idle) begin
            check("mul_a", 32'(bus.mul_a), 32'(opa));
            check("mul_b", 32'(bus.mul_b), 32'(opb));
        end else begin
            check("ops_done", 32'(ops_done), 32'(exp_ops));
        end
        if (r0 || r1) begin
            own = r1 ? 1 : 0;
            lg = r1;
            hs = k;
            idle_from = k + 8;
            opa = r1 ? a1 : a0;
            opb = r1 ? b1 : b0;
            prod = 8'(smul(opa, opb));
        end
        @(posedge clk);
        #1;
        if (r0) v0 = 1'b0;
        if (r1) v1 = 1'b0;
        k++;
    endtask

    task automatic run_ops(int max_cycles);
        int n;
        n = 0;
        do begin
            drive();
            step();
            n++;
        end while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || k < idle_from)
                   && n < max_cycles);
        if (n >= max_cycles) check("run_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        drive();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        k += 2;
        idle_from = k;
        hs = -100;
        lg = 1'b1;
        exp_p0 = '0;
        exp_p1 = '0;
        exp_ops = '0;
        nops = 0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ops", 32'(ops_done), 32'(0));
        check("rst_start", 32'(bus.mul_start), 32'(0));
        check("rst_mul_a", 32'(bus.mul_a), 32'(0));
        check("rst_mul_b", 32'(bus.mul_b), 32'(0));
        check("rst_rsp0", 32'({bus.rsp0_valid, bus.rsp0_p}), 32'(0));
        check("rst_rsp1", 32'({bus.rsp1_valid, bus.rsp1_p}), 32'(0));
    endtask

    initial begin
        int n;
        q0.delete();
        q1.delete();
        do_reset();

        // Single op on requester 0.
        q0.push_back('{4'd3, 4'hE});
        run_ops(50);
        check("t1_p", 32'(bus.rsp0_p), 32'(8'hFA));
        check("t1_ops", 32'(ops_done), 32'(1));
        check("t1_rsp1", 32'(bus.rsp1_p), 32'(0));

        // Simultaneous arrival from reset.
        do_reset();
        q0.push_back('{4'd2, 4'd5});
        q1.push_back('{4'hD, 4'd4});
        run_ops(50);
        check("t2_p0", 32'(bus.rsp0_p), 32'(8'h0A));
        check("t2_p1", 32'(bus.rsp1_p), 32'(8'hF4));
        check("t2_ops", 32'(ops_done), 32'(2));

        // Continuous contention.
        for (int i = 0; i < 6; i++) begin
            q0.push_back('{4'($urandom), 4'($urandom)});
            q1.push_back('{4'($urandom), 4'($urandom)});
        end
        run_ops(200);

        // Corner operands.
        q0.push_back('{4'h8, 4'h8});
        run_ops(50);
        check("c_m8m8", 32'(bus.rsp0_p), 32'(8'h40));
        q0.push_back('{4'h8, 4'h7});
        run_ops(50);
        check("c_m8p7", 32'(bus.rsp0_p), 32'(8'hC8));
        q1.push_back('{4'h7, 4'h7});
        run_ops(50);
        check("c_p7p7", 32'(bus.rsp1_p), 32'(8'h31));
        q1.push_back('{4'h0, 4'hF});
        run_ops(50);
        check("c_0m1", 32'(bus.rsp1_p), 32'(8'h00));

        // Reset while the multiplier is in flight.
        q0.push_back('{4'd5, 4'd3});
        n = 0;
        do begin
            drive();
            step();
            n++;
        end while (k != hs + 3 && n < 50);
        if (n >= 50) check("mid_timeout", 32'(n), 32'(0));
        do_reset();
        q1.push_back('{4'd6, 4'hB});
        drive();
        step();
        q0.push_back('{4'd1, 4'd1});
        run_ops(50);
        check("mr_p1", 32'(bus.rsp1_p), 32'(8'hE2));
        check("mr_p0", 32'(bus.rsp0_p), 32'(8'h01));
        check("mr_ops", 32'(ops_done), 32'(2));

        // Random traffic long enough to wrap the op counter.
        rnd = 1'b1;
        n = 0;
        while (nops < 262 && n < 8000) begin
            drive();
            step();
            n++;
        end
        if (n >= 8000) check("wrap_timeout", 32'(n), 32'(0));
        rnd = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        run_ops(50);
        check("wrap_ops", 32'(ops_done), 32'(nops % 256));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
